// File: rtl/multicycle_control_pkg.sv
// Shared constants for the multi-cycle controller: opcodes, state encodings,
// datapath select codes and the packed control-word layout.
package multicycle_control_pkg;

  localparam int WORD_SIZE = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [3:0] ST_FETCH  = 4'd0;
  localparam logic [3:0] ST_DECODE = 4'd1;
  localparam logic [3:0] ST_MEMADR = 4'd2;
  localparam logic [3:0] ST_MEMRD  = 4'd3;
  localparam logic [3:0] ST_MEMWB  = 4'd4;
  localparam logic [3:0] ST_MEMWR  = 4'd5;
  localparam logic [3:0] ST_EXEC   = 4'd6;
  localparam logic [3:0] ST_ALUWB  = 4'd7;
  localparam logic [3:0] ST_BRANCH = 4'd8;
  localparam logic [3:0] ST_ADDIEX = 4'd9;
  localparam logic [3:0] ST_ADDIWB = 4'd10;
  localparam logic [3:0] ST_JUMP   = 4'd11;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [1:0] SRC_B_REG     = 2'b00;
  localparam logic [1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] SRC_B_IMM     = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

  typedef struct packed {
    logic       mem_req;
    logic       i_or_d;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath/memory signal bundle. The controller is the master:
// it drives every select and strobe and reads the opcode and memory ready.
interface multicycle_control_if;
  logic [5:0] instr_op;
  logic       mem_ready;
  logic       mem_req;
  logic       i_or_d;
  logic       mem_write;
  logic       ir_write;
  logic       pc_write;
  logic       pc_write_cond;
  logic [1:0] pc_source;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       instr_done;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  instr_op, mem_ready,
    output mem_req, i_or_d, mem_write, ir_write, pc_write, pc_write_cond,
           pc_source, alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg,
           reg_write, instr_done, illegal_op, state
  );

  modport slave (
    output instr_op, mem_ready,
    input  mem_req, i_or_d, mem_write, ir_write, pc_write, pc_write_cond,
           pc_source, alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg,
           reg_write, instr_done, illegal_op, state
  );
endinterface

// File: rtl/multicycle_control_next_state.sv
// Combinational next-state and Moore output decode; mem_ready only affects
// the FETCH, MEMRD and MEMWR states.
module multicycle_control_next_state
  import multicycle_control_pkg::*;
(
  input  logic [3:0] state_i,
  input  logic [5:0] instr_op_i,
  input  logic       mem_ready_i,
  output logic [3:0] state_d_o,
  output ctrl_t      ctrl_o
);

  always_comb begin
    state_d_o = ST_FETCH;
    ctrl_o    = '0;
    case (state_i)
      ST_FETCH: begin
        ctrl_o.mem_req   = 1'b1;
        ctrl_o.alu_src_b = SRC_B_FOUR;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
        state_d_o        = mem_ready_i ? ST_DECODE : ST_FETCH;
      end
      ST_DECODE: begin
        // Branch target is precomputed here so BRANCH needs only one cycle.
        ctrl_o.alu_src_b = SRC_B_IMM_SH2;
        case (instr_op_i)
          OP_LW, OP_SW: state_d_o = ST_MEMADR;
          OP_RTYPE:     state_d_o = ST_EXEC;
          OP_BEQ:       state_d_o = ST_BRANCH;
          OP_ADDI:      state_d_o = ST_ADDIEX;
          OP_J:         state_d_o = ST_JUMP;
          default: begin
            ctrl_o.illegal_op = 1'b1;
            state_d_o         = ST_FETCH;
          end
        endcase
      end
      ST_MEMADR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRC_B_IMM;
        if (instr_op_i == OP_LW) begin
          state_d_o = ST_MEMRD;
        end else if (instr_op_i == OP_SW) begin
          state_d_o = ST_MEMWR;
        end
      end
      ST_MEMRD: begin
        ctrl_o.mem_req = 1'b1;
        ctrl_o.i_or_d  = 1'b1;
        state_d_o      = mem_ready_i ? ST_MEMWB : ST_MEMRD;
      end
      ST_MEMWB: begin
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      ST_MEMWR: begin
        // The store retires in the cycle memory accepts it.
        ctrl_o.mem_req    = 1'b1;
        ctrl_o.i_or_d     = 1'b1;
        ctrl_o.mem_write  = mem_ready_i;
        ctrl_o.instr_done = mem_ready_i;
        state_d_o         = mem_ready_i ? ST_FETCH : ST_MEMWR;
      end
      ST_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_op    = ALU_OP_FUNCT;
        state_d_o        = ST_ALUWB;
      end
      ST_ALUWB: begin
        ctrl_o.reg_dst    = 1'b1;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      ST_BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_op        = ALU_OP_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PC_SRC_ALUOUT;
        ctrl_o.instr_done    = 1'b1;
      end
      ST_ADDIEX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRC_B_IMM;
        state_d_o        = ST_ADDIWB;
      end
      ST_ADDIWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      ST_JUMP: begin
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.pc_source  = PC_SRC_JUMP;
        ctrl_o.instr_done = 1'b1;
      end
      default: begin
        state_d_o = ST_FETCH;
        ctrl_o    = '0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS-subset sequencing controller: state register plus output
// gating; all decode lives in multicycle_control_next_state.
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_control_if.master bus
);

  logic [3:0] state_q;
  logic [3:0] state_d;
  ctrl_t      ctrl;
  ctrl_t      ctrl_out;

  multicycle_control_next_state u_next_state (
    .state_i     (state_q),
    .instr_op_i  (bus.instr_op),
    .mem_ready_i (bus.mem_ready),
    .state_d_o   (state_d),
    .ctrl_o      (ctrl)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // FETCH would otherwise raise mem_req during reset; hold everything quiet.
  assign ctrl_out = rst_n ? ctrl : '0;

  assign bus.mem_req       = ctrl_out.mem_req;
  assign bus.i_or_d        = ctrl_out.i_or_d;
  assign bus.mem_write     = ctrl_out.mem_write;
  assign bus.ir_write      = ctrl_out.ir_write;
  assign bus.pc_write      = ctrl_out.pc_write;
  assign bus.pc_write_cond = ctrl_out.pc_write_cond;
  assign bus.pc_source     = ctrl_out.pc_source;
  assign bus.alu_src_a     = ctrl_out.alu_src_a;
  assign bus.alu_src_b     = ctrl_out.alu_src_b;
  assign bus.alu_op        = ctrl_out.alu_op;
  assign bus.reg_dst       = ctrl_out.reg_dst;
  assign bus.mem_to_reg    = ctrl_out.mem_to_reg;
  assign bus.reg_write     = ctrl_out.reg_write;
  assign bus.instr_done    = ctrl_out.instr_done;
  assign bus.illegal_op    = ctrl_out.illegal_op;
  assign bus.state         = rst_n ? state_q : ST_FETCH;

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle sequencing controller for the MIPS-subset CPU. It replaces the single-cycle combinational control unit when the datapath shares one memory port for instruction and data and holds IR, MDR, A/B and ALUOut registers. A Moore state machine steps each instruction through fetch, decode, execute, memory and writeback. It stalls on a memory ready handshake and drives every datapath mux select and write enable.

## Interface
- WORD_SIZE, 32, datapath word width (the controller only uses it for documentation/consistency checks)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- instr_op  in  6  opcode field IR[31:26], taken from the instruction register
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access requested
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_write  out  1  data memory write strobe
- ir_write  out  1  load the instruction register
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load gated by ALU zero (BEQ)
- pc_source  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
- alu_src_a  out  1  ALU operand A select: 0 = PC, 1 = A register
- alu_src_b  out  2  ALU operand B select: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- alu_op  out  2  to the ALU control block: 00 = add, 01 = sub, 10 = funct field
- reg_dst  out  1  write register select: 0 = rt, 1 = rd
- mem_to_reg  out  1  register write data select: 0 = ALUOut, 1 = MDR
- reg_write  out  1  register file write enable
- instr_done  out  1  one-cycle pulse when an instruction retires
- illegal_op  out  1  one-cycle pulse on an unsupported opcode
- state  out  4  current state encoding (debug)

## Operation
- Opcodes: R-type 0x00, LW 0x23, SW 0x2B, BEQ 0x04, ADDI 0x08, J 0x02.
- States, with outputs that are asserted (all others 0):
  - FETCH: mem_req, alu_src_b=01. ir_write and pc_write are each equal to mem_ready. Stay while !mem_ready, else go to DECODE.
  - DECODE: alu_src_b=11 (precompute the branch target). Next state by opcode: LW/SW→MEMADR, R→EXEC, BEQ→BRANCH, ADDI→ADDIEX, J→JUMP. Any other opcode pulses illegal_op and returns to FETCH.
  - MEMADR: alu_src_a=1, alu_src_b=10. LW→MEMRD, SW→MEMWR.
  - MEMRD: mem_req, i_or_d. Stay while !mem_ready, else go to MEMWB.
  - MEMWB: mem_to_reg, reg_write, instr_done. Go to FETCH.
  - MEMWR: mem_req, i_or_d, mem_write=mem_ready, instr_done=mem_ready. Stay while !mem_ready, else go to FETCH.
  - EXEC: alu_src_a=1, alu_op=10. Go to ALUWB.
  - ALUWB: reg_dst, reg_write, instr_done. Go to FETCH.
  - BRANCH: alu_src_a=1, alu_op=01, pc_write_cond, pc_source=01, instr_done. Go to FETCH.
  - ADDIEX: alu_src_a=1, alu_src_b=10. Go to ADDIWB.
  - ADDIWB: reg_write, instr_done. Go to FETCH.
  - JUMP: pc_write, pc_source=10, instr_done. Go to FETCH.
- instr_op is sampled only in DECODE and MEMADR. The IR is stable from FETCH exit until the next FETCH.
- Unused state encodings go to FETCH on the next edge. No outputs are asserted while in an unused encoding.

## Timing
- State register updates on the rising clk edge. Outputs decode combinationally from the state, plus mem_ready in the three memory states only.
- Reset (rst=0): state=FETCH immediately. While rst=0, all outputs are forced to 0, including mem_req. Outputs follow FETCH from the first cycle after release.
- Reset mid-instruction aborts the instruction: no instr_done, no partial writeback after release.
- Cycles per instruction with zero wait states: R 4, LW 5, SW 4, BEQ 3, J 3, ADDI 4, illegal 2. Each cycle mem_ready is low in FETCH, MEMRD or MEMWR adds exactly one cycle.
- mem_req holds high until the cycle in which mem_ready=1. mem_ready is ignored outside the memory states.
- At most one instr_done or illegal_op pulse occurs per instruction. The two never coincide.

## Structure
- Opcode values, state encodings, and the alu_op and pc_source codes go in the shared cpu_constant_library.v, next to the ALU_* constants.
- One natural sub-module is mc_next_state: combinational next-state and output decode, with the state flop kept in the top.

## Test plan
- Reset: hold rst=0 for 3 cycles with mem_ready=1 → all outputs 0 and state=FETCH. After release, the first cycle shows mem_req=1, ir_write=1, pc_write=1.
- R-type: instr_op=0x00, mem_ready=1 → states FETCH, DECODE, EXEC, ALUWB. ALUWB shows reg_dst=1 and reg_write=1. instr_done pulses on cycle 4.
- LW with 2 wait states in MEMRD: instr_op=0x23 → the state stays in MEMRD for 3 cycles with mem_req=1 and i_or_d=1. MEMWB then shows mem_to_reg=1 and reg_write=1. Total 7 cycles.
- SW with 1 wait state: mem_write=0 in the first MEMWR cycle and 1 in the second. instr_done is asserted in the same cycle as mem_write. The next state is FETCH.
- BEQ then J: BEQ shows pc_write_cond=1 and pc_source=01 on cycle 3. J (0x02) shows pc_write=1 and pc_source=10 on cycle 3.
- Illegal opcode 0x3F → illegal_op pulses in DECODE, instr_done stays 0, and the state returns to FETCH. Separately, asserting rst=0 in ADDIEX means ADDIWB never occurs and no reg_write is issued.
